// File: rtl/out_port_buffered.sv
// Buffered output port: DEPTH-word FIFO ahead of a registered presentation stage (outPort/outValid).
// Latency: 1 edge load-to-pin when the FIFO is empty; writes that find no room are dropped and flag overflow.

module out_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           clear,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_dat,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0]     occ
);
  // Circular buffer with a separate occupancy count; the caller guarantees
  // push only when room exists after this edge's pop.
  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    wr_ptr = '0;
  logic [AW-1:0]    rd_ptr = '0;
  logic [OCC_W-1:0] occ_q  = '0;

  always_ff @(posedge clock) begin
    if (push && !clear) begin
      ram[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_dat = ram[rd_ptr];
  assign occ      = occ_q;
endmodule

module out_port_buffered #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] INIT       = 32'h0
) (
  input  logic                               clock,
  input  logic                               clear,
  input  logic                               enable,
  input  logic [DATA_WIDTH-1:0]              BusMuxOut,
  input  logic                               outAck,
  output logic [DATA_WIDTH-1:0]              outPort,
  output logic                               outValid,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(DEPTH+1):0]           count,
  output logic                               overflow
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int CNT_W = OCC_W + 1;

  logic [DATA_WIDTH-1:0] port_q  = DATA_WIDTH'(INIT);
  logic                  valid_q = 1'b0;
  logic                  ovf_q   = 1'b0;

  logic [DATA_WIDTH-1:0] head_dat;
  logic [OCC_W-1:0]      occ;
  logic                  stage_free;
  logic                  fifo_empty;
  logic                  pop;
  logic                  bypass;
  logic                  room;
  logic                  push;
  logic                  drop;

  // An ack while nothing is presented carries no meaning, so the stage is
  // free only when empty or being consumed this edge.
  assign stage_free = !valid_q || outAck;
  assign fifo_empty = (occ == '0);
  assign pop        = stage_free && !fifo_empty;
  assign bypass     = stage_free && fifo_empty && enable;
  // Room is judged after this edge's pop, which lets full+ack+write proceed.
  assign room       = (occ - OCC_W'(pop)) < OCC_W'(DEPTH);
  assign push       = enable && !bypass && room;
  assign drop       = enable && !bypass && !room;

  out_port_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .clear    (clear),
    .push     (push && !clear),
    .push_dat (BusMuxOut),
    .pop      (pop && !clear),
    .head_dat (head_dat),
    .occ      (occ)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      port_q  <= DATA_WIDTH'(INIT);
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (pop) begin
        port_q  <= head_dat;
        valid_q <= 1'b1;
      end else if (bypass) begin
        port_q  <= BusMuxOut;
        valid_q <= 1'b1;
      end else if (stage_free) begin
        // Data is left in place so the pins never glitch between words.
        valid_q <= 1'b0;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign outPort  = port_q;
  assign outValid = valid_q;
  assign overflow = ovf_q;
  assign full     = (occ == OCC_W'(DEPTH));
  assign empty    = fifo_empty && !valid_q;
  assign count    = CNT_W'(occ) + CNT_W'(valid_q);
endmodule
